// File: rtl/armflow_acc_pkg.sv
// -----------------------------------------------------------------------------
// armflow_acc_pkg
//   Shared constants and types for the partial-sum accumulator.
//
//   ACC_W   : accumulator / result width (33)
//   TERM_W  : width of one input term (11)
//   SUM_W   : adder result width, accumulator plus one carry bit (34)
//   CNT_W   : term counter width; wide enough for the largest legal job (255)
//   state_t : FSM state encoding shared by the RTL and anything observing it
// -----------------------------------------------------------------------------
package armflow_acc_pkg;

   localparam int ACC_W  = 33;
   localparam int TERM_W = 11;
   localparam int SUM_W  = ACC_W + 1;
   localparam int CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage : armflow_acc_pkg

// File: rtl/partial_sum_accumulator_if.sv
// -----------------------------------------------------------------------------
// partial_sum_accumulator_if
//   Bundles the control, term-stream and result signals of the accumulator.
//
//   start     : one-cycle pulse that begins a job (master -> slave)
//   init_val  : seed loaded into the accumulator on start (master -> slave)
//   in_valid  : term beat offered (master -> slave)
//   in_ready  : accumulator can take a term (slave -> master)
//   in_data   : term value (master -> slave)
//   out_valid : result available (slave -> master)
//   out_ready : result consumer ready (master -> slave)
//   out_sum   : accumulator value (slave -> master)
//   out_ovf   : some addition of the job carried out of the top bit
//   busy      : a job is in progress or its result is pending
//
//   Handshake: a transfer happens on a rising clk edge where valid && ready
//   are both high. A source keeps data stable while valid is high and not yet
//   accepted; ready never depends combinationally on the matching valid.
//
//   Modports: master = job issuer / term source / result sink,
//             slave  = the accumulator.
// -----------------------------------------------------------------------------
interface partial_sum_accumulator_if;
   import armflow_acc_pkg::*;

   logic              start;
   logic [ACC_W-1:0]  init_val;
   logic              in_valid;
   logic              in_ready;
   logic [TERM_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_sum;
   logic              out_ovf;
   logic              busy;

   modport master (
      output start, init_val, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf, busy
   );

   modport slave (
      input  start, init_val, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sum, out_ovf, busy
   );

endinterface : partial_sum_accumulator_if

// File: rtl/customAdder33_22.sv
// -----------------------------------------------------------------------------
// customAdder33_22
//   Unsigned adder of a 33-bit accumulator and a zero-extended 11-bit term,
//   producing the full 34-bit sum so the carry out of bit 32 is visible.
//
//   A   : accumulator operand (33 bits)
//   B   : term operand (11 bits, zero-extended internally)
//   Sum : A + B with carry in bit 33
// -----------------------------------------------------------------------------
module customAdder33_22
   import armflow_acc_pkg::*;
(
   input  logic [ACC_W-1:0]  A,
   input  logic [TERM_W-1:0] B,
   output logic [SUM_W-1:0]  Sum
);

   assign Sum = {1'b0, A} + {{(SUM_W - TERM_W){1'b0}}, B};

endmodule : customAdder33_22

// File: rtl/partial_sum_accumulator.sv
// -----------------------------------------------------------------------------
// partial_sum_accumulator
//   Accumulates NUM_TERMS 11-bit terms onto a 33-bit seed. A start pulse loads
//   the seed and opens a job (from any state, discarding whatever was going
//   on); each accepted term is added; after the last term the result is held
//   on out_sum/out_ovf with out_valid until it is taken.
//
//   Build option: define PSA_SATURATE_EN to clamp the accumulator at all-ones
//   on carry-out instead of wrapping. out_ovf behaves the same either way.
//
//   Parameters:
//     NUM_TERMS : terms per job, 1..255
//   Ports:
//     clk       : clock, rising edge
//     rst_n     : asynchronous active-low reset
//     bus       : partial_sum_accumulator_if.slave (start/init, term stream,
//                 result, busy)
//     dbg_state : current FSM state for observation
// -----------------------------------------------------------------------------
module partial_sum_accumulator
   import armflow_acc_pkg::*;
#(
   parameter int NUM_TERMS = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   partial_sum_accumulator_if.slave        bus,
   output state_t                          dbg_state
);

   // Counter value held while the final beat of a job is being accepted.
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TERMS - 1);

`ifdef PSA_SATURATE_EN
   localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
`endif

   state_t            state;
   state_t            state_nxt;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  acc_upd;
   logic [CNT_W-1:0]  cnt;
   logic              ovf;
   logic [SUM_W-1:0]  sum;
   logic              carry;
   logic              accept;
   logic              in_ready_int;
   logic              out_valid_int;
   logic              busy_int;

   // ---------------------------------------------------------------------
   // Adder: the only arithmetic element in the block.
   // ---------------------------------------------------------------------
   customAdder33_22 u_adder (
      .A   (acc),
      .B   (bus.in_data),
      .Sum (sum)
   );

   assign carry = sum[SUM_W-1];

   // in_ready depends only on registered state and start, never on in_valid.
   // A start in ACCUM takes priority over a beat offered in the same cycle.
   assign in_ready_int = (state == ACCUM) && !bus.start;
   assign accept       = bus.in_valid && in_ready_int;

   // Value written into the accumulator for an accepted beat.
   always_comb begin
`ifdef PSA_SATURATE_EN
      // Once clamped, every further non-zero term carries out again and
      // re-clamps, so the accumulator stays pinned for the rest of the job.
      acc_upd = carry ? ACC_MAX : sum[ACC_W-1:0];
`else
      acc_upd = sum[ACC_W-1:0];
`endif
   end

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state and decoded outputs
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt     = state;
      out_valid_int = 1'b0;
      busy_int      = 1'b0;

      case (state)
         IDLE: begin
            state_nxt = IDLE;
         end
         ACCUM: begin
            busy_int = 1'b1;
            if (accept && (cnt == LAST_IDX)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy_int      = 1'b1;
            out_valid_int = 1'b1;
            if (bus.out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // A new job overrides whatever the current state would do next.
      if (bus.start) begin
         state_nxt = ACCUM;
      end
   end

   // ---------------------------------------------------------------------
   // Datapath: accumulator, term counter, sticky overflow
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (bus.start) begin
         acc <= bus.init_val;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (accept) begin
         acc <= acc_upd;
         cnt <= cnt + CNT_W'(1);
         if (carry) begin
            ovf <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign bus.in_ready  = in_ready_int;
   assign bus.out_valid = out_valid_int;
   assign bus.busy      = busy_int;
   assign bus.out_sum   = acc;
   assign bus.out_ovf   = ovf;
   assign dbg_state     = state;

endmodule : partial_sum_accumulator

// File: tb/tb_partial_sum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_partial_sum_accumulator
//   Directed bench for partial_sum_accumulator. Three instances with
//   NUM_TERMS = 4, 2 and 8 share clock and reset; `sel` steers the bench's
//   handshake inputs to one instance and muxes that instance's outputs back.
//   Expected values are hand-computed constants; PSA_SATURATE_EN selects the
//   saturating expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_partial_sum_accumulator;
   import armflow_acc_pkg::*;

`ifdef PSA_SATURATE_EN
   localparam logic [ACC_W-1:0] EXP_OVF_MID = 33'h1_FFFF_FFFF;
   localparam logic [ACC_W-1:0] EXP_OVF_END = 33'h1_FFFF_FFFF;
   localparam logic [ACC_W-1:0] EXP_RST_PRE = 33'h1_FFFF_FFFF;
`else
   localparam logic [ACC_W-1:0] EXP_OVF_MID = 33'd0;
   localparam logic [ACC_W-1:0] EXP_OVF_END = 33'd5;
   localparam logic [ACC_W-1:0] EXP_RST_PRE = 33'd2;
`endif

   // ---------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------
   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------
   // Bench-side drive and observation signals
   // ---------------------------------------------------------------------
   int                sel;
   logic              start;
   logic [ACC_W-1:0]  init_val;
   logic              in_valid;
   logic [TERM_W-1:0] in_data;
   logic              out_ready;

   logic              m_in_ready;
   logic              m_out_valid;
   logic [ACC_W-1:0]  m_out_sum;
   logic              m_out_ovf;
   logic              m_busy;
   state_t            m_state;

   int checks;
   int errors;
   int beat_cnt;

   partial_sum_accumulator_if if4 ();
   partial_sum_accumulator_if if2 ();
   partial_sum_accumulator_if if8 ();
   state_t st4, st2, st8;

   assign if4.start     = start && (sel == 0);
   assign if4.in_valid  = in_valid && (sel == 0);
   assign if4.out_ready = out_ready && (sel == 0);
   assign if4.init_val  = init_val;
   assign if4.in_data   = in_data;

   assign if2.start     = start && (sel == 1);
   assign if2.in_valid  = in_valid && (sel == 1);
   assign if2.out_ready = out_ready && (sel == 1);
   assign if2.init_val  = init_val;
   assign if2.in_data   = in_data;

   assign if8.start     = start && (sel == 2);
   assign if8.in_valid  = in_valid && (sel == 2);
   assign if8.out_ready = out_ready && (sel == 2);
   assign if8.init_val  = init_val;
   assign if8.in_data   = in_data;

   partial_sum_accumulator #(.NUM_TERMS(4)) dut4 (
      .clk (clk), .rst_n (rst_n), .bus (if4), .dbg_state (st4)
   );
   partial_sum_accumulator #(.NUM_TERMS(2)) dut2 (
      .clk (clk), .rst_n (rst_n), .bus (if2), .dbg_state (st2)
   );
   partial_sum_accumulator #(.NUM_TERMS(8)) dut8 (
      .clk (clk), .rst_n (rst_n), .bus (if8), .dbg_state (st8)
   );

   always_comb begin
      case (sel)
         1: begin
            m_in_ready = if2.in_ready; m_out_valid = if2.out_valid;
            m_out_sum = if2.out_sum; m_out_ovf = if2.out_ovf;
            m_busy = if2.busy; m_state = st2;
         end
         2: begin
            m_in_ready = if8.in_ready; m_out_valid = if8.out_valid;
            m_out_sum = if8.out_sum; m_out_ovf = if8.out_ovf;
            m_busy = if8.busy; m_state = st8;
         end
         default: begin
            m_in_ready = if4.in_ready; m_out_valid = if4.out_valid;
            m_out_sum = if4.out_sum; m_out_ovf = if4.out_ovf;
            m_busy = if4.busy; m_state = st4;
         end
      endcase
   end

   // Beat monitor: inputs change on the falling edge, so mid-low-phase they
   // hold the values the next rising edge will see.
   always @(negedge clk) begin
      #2;
      if (in_valid && m_in_ready) beat_cnt++;
   end

   // ---------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Driver tasks (all return aligned to a falling edge or just after it)
   // ---------------------------------------------------------------------
   task automatic start_job(input logic [ACC_W-1:0] seed);
      @(negedge clk);
      start    = 1'b1;
      init_val = seed;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic send_beat(input logic [TERM_W-1:0] d);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_data  = d;
      #1;
      while (!m_in_ready && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!m_in_ready) check("beat_accept_timeout", m_in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic finish_job(input string tag);
      out_ready = 1'b1;
      #1;
      check({tag, "_valid_at_hs"}, m_out_valid, 1'b1);
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      check({tag, "_idle_state"}, m_state, IDLE);
      check({tag, "_idle_valid"}, m_out_valid, 1'b0);
      check({tag, "_idle_busy"}, m_busy, 1'b0);
   endtask

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      int b0;
      checks    = 0;
      errors    = 0;
      beat_cnt  = 0;
      sel       = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      init_val  = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // Reset state
      #3;
      check("rst_out_valid", m_out_valid, 1'b0);
      check("rst_in_ready", m_in_ready, 1'b0);
      check("rst_busy", m_busy, 1'b0);
      check("rst_out_sum", m_out_sum, 33'd0);
      check("rst_out_ovf", m_out_ovf, 1'b0);
      check("rst_state", m_state, IDLE);
      @(negedge clk);
      rst_n = 1'b1;

      // Four terms back to back, one-cycle result latency
      sel = 0;
      start_job(33'd0);
      check("t1_busy", m_busy, 1'b1);
      b0 = beat_cnt;
      send_beat(11'd1);
      send_beat(11'd2);
      send_beat(11'd3);
      check("t1_valid_before_last", m_out_valid, 1'b0);
      send_beat(11'd4);
      check("t1_valid_after_last", m_out_valid, 1'b1);
      check("t1_sum", m_out_sum, 33'd10);
      check("t1_ovf", m_out_ovf, 1'b0);
      check("t1_beats", beat_cnt - b0, 4);
      finish_job("t1");

      // Carry out of bit 32
      sel = 1;
      start_job(33'h1_FFFF_FFF0);
      send_beat(11'd16);
      check("t2_acc_mid", m_out_sum, EXP_OVF_MID);
      check("t2_ovf_mid", m_out_ovf, 1'b1);
      send_beat(11'd5);
      check("t2_valid", m_out_valid, 1'b1);
      check("t2_sum", m_out_sum, EXP_OVF_END);
      check("t2_ovf", m_out_ovf, 1'b1);
      finish_job("t2");

      // Zero terms are ordinary beats
      start_job(33'd3);
      send_beat(11'd0);
      send_beat(11'd0);
      check("t3_valid", m_out_valid, 1'b1);
      check("t3_sum", m_out_sum, 33'd3);
      finish_job("t3");

      // Result held under back-pressure; DONE ignores the term stream
      sel = 0;
      start_job(33'd7);
      b0 = beat_cnt;
      for (int i = 0; i < 4; i++) send_beat(11'd1);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = (i % 2 == 0) ? 11'h555 : 11'h2AA;
         #1;
         check("t4_hold_valid", m_out_valid, 1'b1);
         check("t4_hold_sum", m_out_sum, 33'd11);
         check("t4_hold_in_ready", m_in_ready, 1'b0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("t4_beats", beat_cnt - b0, 4);
      finish_job("t4");

      // Restart mid-job discards the partial sum
      start_job(33'd50);
      send_beat(11'd9);
      send_beat(11'd9);
      start_job(33'd100);
      check("t5_sum_after_restart", m_out_sum, 33'd100);
      b0 = beat_cnt;
      send_beat(11'd1);
      send_beat(11'd2);
      send_beat(11'd3);
      check("t5_valid_early", m_out_valid, 1'b0);
      send_beat(11'd4);
      check("t5_valid", m_out_valid, 1'b1);
      check("t5_sum", m_out_sum, 33'd110);
      check("t5_ovf", m_out_ovf, 1'b0);
      check("t5_beats", beat_cnt - b0, 4);
      finish_job("t5");

      // Asynchronous reset in the middle of a job
      sel = 1;
      start_job(33'h1_FFFF_FFFF);
      send_beat(11'd3);
      check("t6_pre_sum", m_out_sum, EXP_RST_PRE);
      check("t6_pre_ovf", m_out_ovf, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      check("t6_rst_sum", m_out_sum, 33'd0);
      check("t6_rst_ovf", m_out_ovf, 1'b0);
      check("t6_rst_busy", m_busy, 1'b0);
      check("t6_rst_in_ready", m_in_ready, 1'b0);
      check("t6_rst_valid", m_out_valid, 1'b0);
      @(negedge clk);
      #3;
      rst_n = 1'b1;
      b0 = beat_cnt;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 11'd7;
         #1;
         check("t6_post_in_ready", m_in_ready, 1'b0);
         check("t6_post_state", m_state, IDLE);
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("t6_post_beats", beat_cnt - b0, 0);
      start_job(33'd1);
      send_beat(11'd2);
      send_beat(11'd3);
      check("t6_new_valid", m_out_valid, 1'b1);
      check("t6_new_sum", m_out_sum, 33'd6);
      check("t6_new_ovf", m_out_ovf, 1'b0);
      finish_job("t6");

      // Gappy stream of maximum terms, eight per job
      sel = 2;
      start_job(33'd0);
      b0 = beat_cnt;
      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send_beat(11'd2047);
      end
      check("t7_valid", m_out_valid, 1'b1);
      check("t7_sum", m_out_sum, 33'd16376);
      check("t7_ovf", m_out_ovf, 1'b0);
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      check("t7_beats", beat_cnt - b0, 8);
      check("t7_sum_held", m_out_sum, 33'd16376);
      finish_job("t7");

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_partial_sum_accumulator
